mb_tx_flit_arbiter: RTL



---
 rtl/mb_tx_flit_arbiter_pkg.sv | 18 +
 rtl/mb_tx_flit_arbiter_if.sv | 38 +++
 rtl/mb_tx_flit_arbiter_rr_picker.sv | 40 ++++
 rtl/mb_tx_flit_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mb_tx_flit_arbiter_pkg.sv
// Shared mainband definitions: flit geometry, flit type and arbiter FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mb_pkg;

  localparam int FLIT_BYTES     = 64;
  localparam int MB_LANES       = 16;
  localparam int FRAGS_PER_FLIT = 4;

  // One full mainband flit, byte 0 first.
  typedef logic [FLIT_BYTES-1:0][7:0] flit_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_e;

endpackage : mb_pkg

// File: rtl/mb_tx_flit_arbiter_if.sv
// Bundle of requester-side and serializer-side signals of the TX flit arbiter.
// Latency: n/a (wires only).
// Backpressure: carries req_ready_o pulses toward requesters and flit_ready_i from the serializer.
//
// Modports:
//   master - the arbiter: consumes requests, flit_ready_i and credit returns;
//            drives capture pulses, the presented flit and the credit count.
//   slave  - the environment (requesters + serializer + credit source).
interface mb_tx_flit_arbiter_if #(
  parameter int NUM_REQ      = 2,
  parameter int RX_BUF_DEPTH = 2
);
  import mb_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int CR_W = $clog2(RX_BUF_DEPTH) + 1;

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0][63:0][7:0] req_flit_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          flit_valid_o;
  flit_t                         flit_data_o;
  logic [ID_W-1:0]               flit_grant_id_o;
  logic                          flit_ready_i;
  logic                          credit_return_i;
  logic [CR_W-1:0]               credits_o;

  modport master (
    input  req_valid_i, req_flit_i, flit_ready_i, credit_return_i,
    output req_ready_o, flit_valid_o, flit_data_o, flit_grant_id_o, credits_o
  );

  modport slave (
    output req_valid_i, req_flit_i, flit_ready_i, credit_return_i,
    input  req_ready_o, flit_valid_o, flit_data_o, flit_grant_id_o, credits_o
  );

endinterface : mb_tx_flit_arbiter_if

// File: rtl/mb_tx_flit_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or above ptr, wrapping, as one-hot and index.
// Latency: combinational.
// Backpressure: none; the caller decides whether the pick is used.
//
// Ports:
//   req       - request vector
//   ptr       - highest-priority index this cycle (must be < NUM_REQ)
//   grant_oh  - one-hot winner (zero when no request)
//   grant_idx - binary winner index (zero when no request)
//   grant_vld - at least one request present
module mb_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_vld
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    // Scan NUM_REQ positions starting at ptr; the first hit wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!grant_vld && req[cand]) begin
        grant_vld      = 1'b1;
        grant_idx      = cand;
        grant_oh[cand] = 1'b1;
      end
    end
  end

endmodule : mb_rr_picker

// File: rtl/mb_tx_flit_arbiter.sv
// Mainband TX flit arbiter: shares the serializer between NUM_REQ requesters, one 64-byte flit at a time.
// Latency: req_ready_o pulses in the capture cycle, flit_valid_o rises the next cycle; one idle cycle after each accept.
// Backpressure: flit held stable until flit_ready_i; no capture while remote credits are zero.
//
// Ports:
//   clk, reset_n - block clock, asynchronous active-low reset
//   bus (master) - req_valid_i/req_flit_i/req_ready_o per requester,
//                  flit_valid_o/flit_data_o/flit_grant_id_o/flit_ready_i toward the serializer,
//                  credit_return_i/credits_o for remote RX buffer accounting.
// Build option: MB_ARB_STRICT_PRIO_EN gives requester 0 absolute priority; the rest share round robin.
module mb_tx_flit_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int RX_BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mb_tx_flit_arbiter_if.master bus
);
  import mb_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int CR_W = $clog2(RX_BUF_DEPTH) + 1;
  localparam logic [CR_W-1:0] CR_MAX = CR_W'(RX_BUF_DEPTH);

  arb_state_e         state_q, state_d;
  flit_t              flit_q;
  logic [ID_W-1:0]    id_q;
  logic [CR_W-1:0]    credits_q;
  logic [ID_W-1:0]    rr_ptr_q;

  logic [NUM_REQ-1:0] req_rr;
  logic [NUM_REQ-1:0] pick_oh;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_vld;
  logic [ID_W-1:0]    win_idx;
  logic               win_vld;
  logic               cap;
  logic               accept;

  // Pointer after a grant to id: id+1 modulo NUM_REQ. With strict priority
  // index 0 never takes part in the rotation, so a wrap lands on 1.
  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] id);
    logic [ID_W-1:0] n;
    n = (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
`ifdef MB_ARB_STRICT_PRIO_EN
    if (n == '0) n = ID_W'(1);
`endif
    return n;
  endfunction

  // ---------------------------------------------------------------- winner
`ifdef MB_ARB_STRICT_PRIO_EN
  localparam logic [NUM_REQ-1:0] RR_MASK = ~NUM_REQ'(1);
  assign req_rr  = bus.req_valid_i & RR_MASK;
  assign win_vld = bus.req_valid_i[0] | pick_vld;
  assign win_idx = bus.req_valid_i[0] ? '0 : pick_idx;
`else
  assign req_rr  = bus.req_valid_i;
  assign win_vld = pick_vld;
  assign win_idx = pick_idx;
`endif

  mb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req       (req_rr),
    .ptr       (rr_ptr_q),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .grant_vld (pick_vld)
  );

  // Only the index is needed; the one-hot form is rebuilt from win_idx so
  // that the strict-priority override is covered as well.
  logic unused_pick_oh;
  assign unused_pick_oh = ^pick_oh;

  assign cap    = (state_q == IDLE) && (credits_q != '0) && win_vld;
  assign accept = (state_q == SEND) && bus.flit_ready_i;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cap)    state_d = SEND;
      SEND: if (accept) state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- flit register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flit_q <= '0;
      id_q   <= '0;
    end else if (cap) begin
      flit_q <= bus.req_flit_i[win_idx];
      id_q   <= win_idx;
    end
  end

  // ---------------------------------------------------------------- round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
    end else if (accept) begin
`ifdef MB_ARB_STRICT_PRIO_EN
      // Priority grants to requester 0 leave the rotation untouched.
      if (id_q != '0) rr_ptr_q <= ptr_after(id_q);
`else
      rr_ptr_q <= ptr_after(id_q);
`endif
    end
  end

  // ---------------------------------------------------------------- credits
  // A return coinciding with an accept cancels out; a lone return at the
  // maximum is dropped so the count never exceeds the remote buffer depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits_q <= CR_MAX;
    end else begin
      unique case ({accept, bus.credit_return_i})
        2'b10:   credits_q <= credits_q - 1'b1;
        2'b01:   if (credits_q != CR_MAX) credits_q <= credits_q + 1'b1;
        default: credits_q <= credits_q;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  // The capture pulse is combinational from the registered state; gating it
  // with reset_n keeps it at zero while reset is held, like the other outputs.
  assign bus.req_ready_o     = (cap && reset_n) ? (NUM_REQ'(1) << win_idx) : '0;
  assign bus.flit_valid_o    = (state_q == SEND);
  assign bus.flit_data_o     = flit_q;
  assign bus.flit_grant_id_o = id_q;
  assign bus.credits_o       = credits_q;

endmodule : mb_tx_flit_arbiter
